// File: rtl/ads2_spi_master.sv
// ADS2 SPI master (mode 1, MSB first). It sends a burst of config frames and
// then alternates channel-0/channel-1 command frames while run is held high.
module ads2_spi_master #(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 8,
  parameter int CFG_WORDS  = 6
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        run_i,
  input  logic [15:0] cfg_data_i,
  input  logic [15:0] cmd_ch0_i,
  input  logic [15:0] cmd_ch1_i,
  input  logic        ads_dout_i,
  output logic [3:0]  cfg_idx_o,
  output logic        ads_cs_o,
  output logic        ads_sclk_o,
  output logic        ads_din_o,
  output logic [15:0] receive_data_o,
  output logic [15:0] pkg_num_o,
  output logic        frame_done_o,
  output logic        busy_o
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  localparam int CNT_MAX = (2*CLK_DIV > GAP_CYCLES) ? 2*CLK_DIV : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DIV_M1 = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] PER_M1 = CW'(2*CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_M1 = CW'(GAP_CYCLES - 1);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [15:0]   tx_q, tx_d, rx_q, rx_d, rd_q, rd_d, pkg_q, pkg_d;
  logic          cs_q, cs_d, sclk_q, sclk_d, din_q, din_d;
  logic          fd_q, fd_d, tog_q, tog_d, is_cmd_q, is_cmd_d;
  logic [1:0]    sync_q;
  logic          cfg_sel;
  logic [15:0]   word;

  assign cfg_sel   = (pkg_q < 16'(CFG_WORDS));
  assign cfg_idx_o = cfg_sel ? pkg_q[3:0] : 4'(CFG_WORDS - 1);
  assign word      = cfg_sel ? cfg_data_i : (tog_q ? cmd_ch1_i : cmd_ch0_i);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    rd_d     = rd_q;
    pkg_d    = pkg_q;
    cs_d     = cs_q;
    sclk_d   = sclk_q;
    din_d    = din_q;
    fd_d     = 1'b0;
    tog_d    = tog_q;
    is_cmd_d = is_cmd_q;
    case (state_q)
      ST_IDLE: begin
        cs_d   = 1'b1;
        sclk_d = 1'b0;
        if (run_i) begin
          pkg_d   = '0;
          tog_d   = 1'b0;
          cs_d    = 1'b0;
          cnt_d   = '0;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_q == DIV_M1) begin
          // word is latched here, so later input changes miss this frame
          tx_d     = {word[14:0], 1'b0};
          din_d    = word[15];
          sclk_d   = 1'b1;
          cnt_d    = '0;
          bit_d    = '0;
          is_cmd_d = ~cfg_sel;
          state_d  = ST_SHIFT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_SHIFT: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == DIV_M1) begin
          sclk_d = 1'b0;
          rx_d   = {rx_q[14:0], sync_q[1]};
        end
        if (cnt_q == PER_M1) begin
          cnt_d = '0;
          if (bit_q == 4'd15) begin
            state_d = ST_HOLD;
          end else begin
            bit_d  = bit_q + 4'd1;
            sclk_d = 1'b1;
            din_d  = tx_q[15];
            tx_d   = {tx_q[14:0], 1'b0};
          end
        end
      end
      ST_HOLD: begin
        if (cnt_q == DIV_M1) begin
          cnt_d   = '0;
          cs_d    = 1'b1;
          rd_d    = rx_q;
          pkg_d   = (pkg_q == 16'hFFFF) ? pkg_q : pkg_q + 16'd1;
          fd_d    = 1'b1;
          if (is_cmd_q) tog_d = ~tog_q;
          state_d = ST_GAP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_M1) begin
          cnt_d = '0;
          if (run_i) begin
            cs_d    = 1'b0;
            state_d = ST_SETUP;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        cs_d    = 1'b1;
        sclk_d  = 1'b0;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
      rd_q     <= '0;
      pkg_q    <= '0;
      cs_q     <= 1'b1;
      sclk_q   <= 1'b0;
      din_q    <= 1'b0;
      fd_q     <= 1'b0;
      tog_q    <= 1'b0;
      is_cmd_q <= 1'b0;
      sync_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      rd_q     <= rd_d;
      pkg_q    <= pkg_d;
      cs_q     <= cs_d;
      sclk_q   <= sclk_d;
      din_q    <= din_d;
      fd_q     <= fd_d;
      tog_q    <= tog_d;
      is_cmd_q <= is_cmd_d;
      sync_q   <= {sync_q[0], ads_dout_i};
    end
  end

  assign ads_cs_o       = cs_q;
  assign ads_sclk_o     = sclk_q;
  assign ads_din_o      = din_q;
  assign receive_data_o = rd_q;
  assign pkg_num_o      = pkg_q;
  assign frame_done_o   = fd_q;
  assign busy_o         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ads2_spi_master.sv
// Bench for ads2_spi_master: a slave model answers every frame with A5C3 and
// records what it received; a monitor checks each completed frame against a queue.
module tb_ads2_spi_master;

  logic        clk = 1'b0;
  logic        rst_n, run, ads_dout;
  logic [15:0] cfg_data, cmd_ch0, cmd_ch1;
  logic [3:0]  cfg_idx;
  logic        ads_cs, ads_sclk, ads_din, frame_done, busy;
  logic [15:0] receive_data, pkg_num;

  always #5 clk = ~clk;

  assign cfg_data = 16'h8000 + {12'h000, cfg_idx};

  ads2_spi_master dut (
    .clk_i(clk), .rst_n_i(rst_n), .run_i(run), .cfg_data_i(cfg_data),
    .cmd_ch0_i(cmd_ch0), .cmd_ch1_i(cmd_ch1), .ads_dout_i(ads_dout),
    .cfg_idx_o(cfg_idx), .ads_cs_o(ads_cs), .ads_sclk_o(ads_sclk),
    .ads_din_o(ads_din), .receive_data_o(receive_data), .pkg_num_o(pkg_num),
    .frame_done_o(frame_done), .busy_o(busy)
  );

  typedef struct {
    logic [15:0] word;
    logic [15:0] pkg;
    bit          per;
  } exp_t;

  exp_t        q[$];
  int          total = 0, bad = 0;
  int          cyc = 0, last_fd = 0, lowcnt = 0, hb = 0;
  logic        prev_cs = 1'b1, prev_fd = 1'b0;
  logic [15:0] resp = 16'hA5C3, cap = '0;
  int          sidx = 15;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Slave: drives dout on SCLK rise, captures din on SCLK fall
  initial ads_dout = 1'b0;
  always @(posedge ads_sclk or negedge ads_cs) begin
    if (ads_sclk) begin
      if (sidx >= 0) ads_dout = resp[sidx];
      sidx = sidx - 1;
    end else begin
      sidx = 15;
    end
  end
  always @(negedge ads_sclk) if (!ads_cs) cap = {cap[14:0], ads_din};

  // Monitor
  initial forever begin
    @(negedge clk);
    cyc++;
    if (!ads_cs) lowcnt = prev_cs ? 1 : lowcnt + 1;
    prev_cs = ads_cs;
    if (frame_done) hb = 0;
    if (busy && ads_cs) hb++;
    if (frame_done) begin
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_frame pkg=%0h", pkg_num);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("din_word", 32'(cap), 32'(e.word));
        chk("rx_data", 32'(receive_data), 32'h0000A5C3);
        chk("pkg_num", 32'(pkg_num), 32'(e.pkg));
        chk("cs_low_len", 32'(lowcnt), 32'd136);
        chk("cs_high_at_done", 32'(ads_cs), 32'd1);
        chk("sclk_idle", 32'(ads_sclk), 32'd0);
        chk("fd_width", 32'(prev_fd), 32'd0);
        if (e.per) chk("frame_period", 32'(cyc - last_fd), 32'd144);
      end
      last_fd = cyc;
    end
    prev_fd = frame_done;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [15:0] w, input logic [15:0] p, input bit per);
    exp_t e;
    e.word = w; e.pkg = p; e.per = per;
    q.push_back(e);
  endtask

  task automatic wait_q(input int left, input int budget);
    int n = 0;
    while (q.size() > left && n < budget) begin tick(); n++; end
    if (q.size() > left) begin
      total++; bad++;
      $display("FAIL timeout_frames pending=%0d want=%0d", q.size(), left);
      while (q.size() > left) void'(q.pop_front());
    end
  endtask

  task automatic wait_cs_low(input int budget);
    int n = 0;
    while (ads_cs && n < budget) begin tick(); n++; end
    if (ads_cs) begin total++; bad++; $display("FAIL timeout_cs_low act=1 exp=0"); end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin tick(); n++; end
    chk("idle_reached", 32'(busy), 32'd0);
    chk("busy_fall_gap", 32'(hb), 32'd8);
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; cmd_ch0 = 16'hC38B; cmd_ch1 = 16'hD38B;
    repeat (3) tick();
    chk("rst_cs", 32'(ads_cs), 32'd1);
    chk("rst_sclk", 32'(ads_sclk), 32'd0);
    chk("rst_din", 32'(ads_din), 32'd0);
    chk("rst_rx", 32'(receive_data), 32'd0);
    chk("rst_pkg", 32'(pkg_num), 32'd0);
    chk("rst_cfg_idx", 32'(cfg_idx), 32'd0);
    chk("rst_fd", 32'(frame_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // six config frames then ch0/ch1/ch0 commands
    for (int i = 0; i < 6; i++) push(16'h8000 + 16'(i), 16'(i + 1), i != 0);
    push(16'hC38B, 16'd7, 1'b1);
    push(16'hD38B, 16'd8, 1'b1);
    push(16'hC38B, 16'd9, 1'b1);
    run = 1'b1;
    wait_q(0, 1500);
    run = 1'b0;
    wait_idle(50);
    repeat (10) tick();
    chk("idle_pkg9", 32'(pkg_num), 32'd9);
    chk("idle_cfg_idx", 32'(cfg_idx), 32'd5);

    // run dropped mid-SHIFT of frame 3
    for (int i = 0; i < 3; i++) push(16'h8000 + 16'(i), 16'(i + 1), i != 0);
    run = 1'b1;
    wait_q(1, 400);
    wait_cs_low(40);
    repeat (40) tick();
    run = 1'b0;
    wait_q(0, 200);
    wait_idle(50);
    repeat (30) tick();
    chk("stop_pkg3", 32'(pkg_num), 32'd3);
    chk("stop_cs", 32'(ads_cs), 32'd1);

    // restart clears pkg_num; reset pulse mid-SHIFT of frame 3
    push(16'h8000, 16'd1, 1'b0);
    push(16'h8001, 16'd2, 1'b1);
    run = 1'b1;
    tick();
    chk("restart_pkg", 32'(pkg_num), 32'd0);
    chk("restart_cfg_idx", 32'(cfg_idx), 32'd0);
    chk("restart_cs", 32'(ads_cs), 32'd0);
    wait_q(0, 400);
    wait_cs_low(40);
    repeat (40) tick();
    rst_n = 1'b0;
    #1;
    chk("abort_cs", 32'(ads_cs), 32'd1);
    chk("abort_sclk", 32'(ads_sclk), 32'd0);
    chk("abort_pkg", 32'(pkg_num), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_fd", 32'(frame_done), 32'd0);
    run = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (20) tick();
    chk("post_abort_cs", 32'(ads_cs), 32'd1);

    // saturation with uninterrupted ch0/ch1 alternation
    push(16'h8000, 16'd1, 1'b0);
    push(16'hC38B, 16'hFFFF, 1'b1);
    push(16'hD38B, 16'hFFFF, 1'b1);
    push(16'hC38B, 16'hFFFF, 1'b1);
    run = 1'b1;
    wait_q(3, 300);
    force dut.pkg_q = 16'hFFFE;
    tick();
    release dut.pkg_q;
    chk("forced_pkg", 32'(pkg_num), 32'h0000FFFE);
    chk("forced_cfg_idx", 32'(cfg_idx), 32'd5);
    wait_cs_low(40);
    repeat (20) tick();
    cmd_ch0 = 16'h1234;
    wait_q(2, 300);
    cmd_ch0 = 16'hC38B;
    wait_q(0, 400);
    run = 1'b0;
    wait_idle(50);
    chk("sat_pkg", 32'(pkg_num), 32'h0000FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
